// File: rtl/data_ram_bus.sv
`default_nettype none
// ============================================================================
//  Module   : data_ram_bus
//  Purpose  : Data-memory slave for the RISC-V core. It has a valid/ready
//             request channel and a single-entry registered response. Stores
//             use byte lanes, and loads are sign- or zero-extended. The block
//             also contains a memory-mapped GPIO output register and a
//             synchronised GPIO input. Illegal accesses raise a fault.
//  Revision : 1.0  initial release
// ============================================================================
module data_ram_bus #(
  parameter int    DEPTH_WORDS = 2048,
  parameter int    GPIO_W      = 8,
  parameter int    IO_BIT      = 29,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
);

  localparam int         c_aw        = $clog2(DEPTH_WORDS);
  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;
  localparam logic [1:0] c_size_bad  = 2'b11;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  logic [31:0]       r_mem [DEPTH_WORDS];
  state_t            r_state;
  logic [GPIO_W-1:0] r_gpio_meta;
  logic [GPIO_W-1:0] r_gpio_sync;

  logic              w_accept;
  logic              w_io;
  logic              w_range_bad;
  logic              w_fault;
  logic              w_ram_we;
  logic              w_gpio_we;
  logic [c_aw-1:0]   w_index;
  logic [3:0]        w_lane_mask;
  logic [31:0]       w_wdata_lanes;
  logic [31:0]       w_ram_shift;
  logic [31:0]       w_ram_load;
  logic [31:0]       w_io_load;
  logic [31:0]       w_gpio_out_ext;
  logic [31:0]       w_gpio_in_ext;
  logic [31:0]       w_load_data;

  // RAM address bits between the index and the IO select bit must be zero.
  generate
    if (IO_BIT - 1 >= c_aw + 2) begin : g_range
      assign w_range_bad = |req_addr[IO_BIT-1:c_aw+2];
    end else begin : g_no_range
      assign w_range_bad = 1'b0;
    end
  endgenerate

  // Address bits above the IO select bit take no part in decoding.
  generate
    if (IO_BIT < 31) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^req_addr[31:IO_BIT+1];
    end
  endgenerate

  // Only one response can be outstanding, so a new request is accepted
  // when the slot is empty or is being drained in the same cycle.
  assign req_ready  = (r_state == S_EMPTY) || resp_ready;
  assign resp_valid = (r_state == S_FULL);
  assign w_accept   = req_valid && req_ready;

  assign w_io    = req_addr[IO_BIT];
  assign w_index = req_addr[c_aw+1:2];

  assign w_fault = (req_size == c_size_bad)
                || ((req_size == c_size_half) && req_addr[0])
                || ((req_size == c_size_word) && (req_addr[1:0] != 2'b00))
                || (!w_io && w_range_bad)
                || (w_io && (req_size != c_size_word));

  assign w_ram_we  = w_accept && req_we && !w_fault && !w_io;
  assign w_gpio_we = w_accept && req_we && !w_fault && w_io && (req_addr[3:2] == 2'b00);

  // A store shifts its data into the lane that the address selects. For a
  // half store, addr[0] is zero, so the same shift also works for halves.
  assign w_wdata_lanes = req_wdata << {req_addr[1:0], 3'b000};

  // Decode the byte-lane write mask from size and the low address bits.
  always_comb begin
    w_lane_mask = 4'b1111;
    case (req_size)
      c_size_byte: w_lane_mask = 4'b0001 << req_addr[1:0];
      c_size_half: w_lane_mask = 4'b0011 << {req_addr[1], 1'b0};
      default:     w_lane_mask = 4'b1111;
    endcase
  end

  // The RAM uses an asynchronous read. A store from the previous cycle is
  // therefore visible to the next load.
  assign w_ram_shift = r_mem[w_index] >> {req_addr[1:0], 3'b000};

  // Extend load data from the addressed lane.
  always_comb begin
    w_ram_load = w_ram_shift;
    case (req_size)
      c_size_byte: w_ram_load = req_unsigned ? {24'd0, w_ram_shift[7:0]}
                                             : {{24{w_ram_shift[7]}}, w_ram_shift[7:0]};
      c_size_half: w_ram_load = req_unsigned ? {16'd0, w_ram_shift[15:0]}
                                             : {{16{w_ram_shift[15]}}, w_ram_shift[15:0]};
      default:     w_ram_load = w_ram_shift;
    endcase
  end

  // Zero-extend the GPIO registers to the full bus width.
  always_comb begin
    w_gpio_out_ext               = 32'd0;
    w_gpio_out_ext[GPIO_W-1:0]   = gpio_out;
    w_gpio_in_ext                = 32'd0;
    w_gpio_in_ext[GPIO_W-1:0]    = r_gpio_sync;
  end

  // IO register read map, selected by the word offset.
  always_comb begin
    w_io_load = 32'd0;
    case (req_addr[3:2])
      2'd0:    w_io_load = w_gpio_out_ext;
      2'd1:    w_io_load = w_gpio_in_ext;
      default: w_io_load = 32'd0;
    endcase
  end

  assign w_load_data = (w_fault || req_we) ? 32'd0 : (w_io ? w_io_load : w_ram_load);

  // Store into the RAM byte lanes. The RAM has no reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_mask[i]) begin
          r_mem[w_index][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  // Response slot: fill it on accept, and drain it when the response is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state    <= S_FULL;
            resp_rdata <= w_load_data;
            resp_fault <= w_fault;
          end
        end
        S_FULL: begin
          if (w_accept) begin
            r_state    <= S_FULL;
            resp_rdata <= w_load_data;
            resp_fault <= w_fault;
          end else if (resp_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // GPIO output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= '0;
    end else if (w_gpio_we) begin
      gpio_out <= req_wdata[GPIO_W-1:0];
    end
  end

  // Two-flop synchroniser for the asynchronous input pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gpio_meta <= '0;
      r_gpio_sync <= '0;
    end else begin
      r_gpio_meta <= gpio_in;
      r_gpio_sync <= r_gpio_meta;
    end
  end

endmodule
`default_nettype wire
